// File: rtl/multi_center_of_mass.sv
// Per-channel centroid engine: accumulates masked pixel coordinates for NUM_CH
// channels, then on tabulate divides each channel's sums serially and streams results.
module multi_center_of_mass #(
    parameter  int NUM_CH     = 4,
    parameter  int X_W        = 11,
    parameter  int Y_W        = 10,
    parameter  int ACC_W      = 32,
    parameter  int MIN_PIXELS = 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [X_W-1:0]    x_in,
    input  logic [Y_W-1:0]    y_in,
    input  logic [NUM_CH-1:0] mask_in,
    input  logic              valid_in,
    input  logic              tabulate_in,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic [CH_W-1:0]   ch_out,
    output logic              found_out,
    output logic              last_out,
    output logic              valid_out,
    output logic              busy_out
);
    localparam logic [ACC_W-1:0] MIN_EFF = (MIN_PIXELS == 0) ? ACC_W'(1) : ACC_W'(MIN_PIXELS);
    localparam int               BIT_W   = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DIVIDE, S_EMIT} state_t;

    state_t                        r_state, w_next;
    logic [NUM_CH-1:0][ACC_W-1:0]  r_xs, r_ys, r_cnt;
    logic [NUM_CH-1:0][ACC_W-1:0]  r_sxs, r_sys, r_scnt;
    logic [NUM_CH-1:0][ACC_W-1:0]  w_xs_n, w_ys_n, w_cnt_n;
    logic [CH_W-1:0]               r_k;
    logic [BIT_W-1:0]              r_bit;
    logic [ACC_W-1:0]              r_rx, r_ry, r_qx, r_qy, r_div;
    logic [ACC_W-1:0]              w_rx_n, w_ry_n, w_qx_n, w_qy_n;
    logic                          w_accept, w_found, w_last;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    // One restoring step: returns {remainder, quotient/dividend shift register}.
    function automatic logic [2*ACC_W-1:0] div_step(input logic [ACC_W-1:0] rem,
                                                    input logic [ACC_W-1:0] q,
                                                    input logic [ACC_W-1:0] d);
        logic [ACC_W:0] sh;
        sh = {rem, q[ACC_W-1]};
        if (sh >= {1'b0, d})
            return {ACC_W'(sh - {1'b0, d}), q[ACC_W-2:0], 1'b1};
        else
            return {sh[ACC_W-1:0], q[ACC_W-2:0], 1'b0};
    endfunction

    assign w_accept  = tabulate_in && (r_state == S_IDLE);
    assign busy_out  = (r_state != S_IDLE);
    assign valid_out = (r_state == S_EMIT);
    assign w_found   = (r_scnt[r_k] >= MIN_EFF);
    assign w_last    = (r_k == LAST_CH);
    assign {w_rx_n, w_qx_n} = div_step(r_rx, r_qx, r_div);
    assign {w_ry_n, w_qy_n} = div_step(r_ry, r_qy, r_div);

    // On accept the live sums restart from zero, plus this cycle's pixel if any.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_xs_n[c]  = (valid_in && mask_in[c]) ? sat_add(w_accept ? '0 : r_xs[c], ACC_W'(x_in))
                                                  : (w_accept ? '0 : r_xs[c]);
            w_ys_n[c]  = (valid_in && mask_in[c]) ? sat_add(w_accept ? '0 : r_ys[c], ACC_W'(y_in))
                                                  : (w_accept ? '0 : r_ys[c]);
            w_cnt_n[c] = (valid_in && mask_in[c]) ? sat_add(w_accept ? '0 : r_cnt[c], ACC_W'(1))
                                                  : (w_accept ? '0 : r_cnt[c]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_xs   <= '0;
            r_ys   <= '0;
            r_cnt  <= '0;
            r_sxs  <= '0;
            r_sys  <= '0;
            r_scnt <= '0;
        end else begin
            r_xs   <= w_xs_n;
            r_ys   <= w_ys_n;
            r_cnt  <= w_cnt_n;
            if (w_accept) begin
                r_sxs  <= r_xs;
                r_sys  <= r_ys;
                r_scnt <= r_cnt;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETUP;
            S_SETUP:  w_next = w_found ? S_DIVIDE : S_EMIT;
            S_DIVIDE: if (r_bit == '0) w_next = S_EMIT;
            S_EMIT:   w_next = w_last ? S_IDLE : S_SETUP;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_bit     <= '0;
            r_rx      <= '0;
            r_ry      <= '0;
            r_qx      <= '0;
            r_qy      <= '0;
            r_div     <= '0;
            x_out     <= '0;
            y_out     <= '0;
            ch_out    <= '0;
            found_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_accept) r_k <= '0;
                S_SETUP: begin
                    if (w_found) begin
                        r_rx  <= '0;
                        r_ry  <= '0;
                        r_qx  <= r_sxs[r_k];
                        r_qy  <= r_sys[r_k];
                        r_div <= r_scnt[r_k];
                        r_bit <= BIT_W'(ACC_W - 1);
                    end else begin
                        x_out     <= '0;
                        y_out     <= '0;
                        ch_out    <= r_k;
                        found_out <= 1'b0;
                        last_out  <= w_last;
                    end
                end
                S_DIVIDE: begin
                    r_rx  <= w_rx_n;
                    r_ry  <= w_ry_n;
                    r_qx  <= w_qx_n;
                    r_qy  <= w_qy_n;
                    r_bit <= r_bit - 1'b1;
                    if (r_bit == '0) begin
                        x_out     <= w_qx_n[X_W-1:0];
                        y_out     <= w_qy_n[Y_W-1:0];
                        ch_out    <= r_k;
                        found_out <= 1'b1;
                        last_out  <= w_last;
                    end
                end
                S_EMIT: r_k <= w_last ? '0 : r_k + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_center_of_mass.sv
// Randomised + directed bench for multi_center_of_mass; two instances (MIN_PIXELS 1 and 3)
// share the stimulus and are scored against an arithmetic per-channel centroid model.
module tb_multi_center_of_mass;
    localparam int NUM_CH = 4;
    localparam int X_W    = 11;
    localparam int Y_W    = 10;
    localparam int ACC_W  = 32;
    localparam int CH_W   = 2;
    localparam longint SAT = 64'hFFFF_FFFF;

    typedef struct {
        int     ch;
        bit     found;
        longint x;
        longint y;
        bit     last;
        longint at;
    } exp_t;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic [X_W-1:0]    x_in = '0;
    logic [Y_W-1:0]    y_in = '0;
    logic [NUM_CH-1:0] mask_in = '0;
    logic              valid_in = 1'b0;
    logic              tabulate_in = 1'b0;

    logic [X_W-1:0]  xo [2];
    logic [Y_W-1:0]  yo [2];
    logic [CH_W-1:0] cho [2];
    logic            fo [2];
    logic            lo [2];
    logic            vo [2];
    logic            bo [2];

    multi_center_of_mass #(.NUM_CH(NUM_CH), .X_W(X_W), .Y_W(Y_W), .ACC_W(ACC_W), .MIN_PIXELS(1)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in), .mask_in(mask_in),
        .valid_in(valid_in), .tabulate_in(tabulate_in), .x_out(xo[0]), .y_out(yo[0]),
        .ch_out(cho[0]), .found_out(fo[0]), .last_out(lo[0]), .valid_out(vo[0]), .busy_out(bo[0]));

    multi_center_of_mass #(.NUM_CH(NUM_CH), .X_W(X_W), .Y_W(Y_W), .ACC_W(ACC_W), .MIN_PIXELS(3)) dut3 (
        .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in), .mask_in(mask_in),
        .valid_in(valid_in), .tabulate_in(tabulate_in), .x_out(xo[1]), .y_out(yo[1]),
        .ch_out(cho[1]), .found_out(fo[1]), .last_out(lo[1]), .valid_out(vo[1]), .busy_out(bo[1]));

    always #5 clk_in = ~clk_in;

    longint edge_n = 0;
    always @(posedge clk_in) edge_n <= edge_n + 1;

    int     n_chk = 0;
    int     n_pass = 0;
    bit     mon_en = 1'b0;
    int     minp [2] = '{1, 3};
    longint lx [2][NUM_CH];
    longint ly [2][NUM_CH];
    longint lc [2][NUM_CH];
    longint acc_e [2] = '{-1, -1};
    longint last_e [2] = '{-1, -1};
    exp_t   sb [2][$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic longint sat(input longint v);
        return (v > SAT) ? SAT : v;
    endfunction

    // Model of one instance for the clock edge E, given the inputs present at that edge.
    task automatic model_edge(input int i, input int x, input int y, input logic [NUM_CH-1:0] m,
                              input logic v, input logic tb, input logic r, input longint E);
        longint t;
        exp_t   e;
        if (r) begin
            for (int c = 0; c < NUM_CH; c++) begin lx[i][c] = 0; ly[i][c] = 0; lc[i][c] = 0; end
            acc_e[i] = -1;
            last_e[i] = -1;
            sb[i].delete();
            return;
        end
        if (tb && E > last_e[i]) begin
            t = E;
            for (int c = 0; c < NUM_CH; c++) begin
                e.ch    = c;
                e.found = (lc[i][c] >= minp[i]);
                e.x     = e.found ? lx[i][c] / lc[i][c] : 0;
                e.y     = e.found ? ly[i][c] / lc[i][c] : 0;
                e.last  = (c == NUM_CH - 1);
                t      += e.found ? ACC_W + 2 : 2;
                e.at    = t;
                sb[i].push_back(e);
                lx[i][c] = 0; ly[i][c] = 0; lc[i][c] = 0;
            end
            acc_e[i]  = E;
            last_e[i] = t;
        end
        if (v)
            for (int c = 0; c < NUM_CH; c++)
                if (m[c]) begin
                    lx[i][c] = sat(lx[i][c] + x);
                    ly[i][c] = sat(ly[i][c] + y);
                    lc[i][c] = sat(lc[i][c] + 1);
                end
    endtask

    task automatic drive(input int x, input int y, input logic [NUM_CH-1:0] m,
                         input logic v, input logic tb, input logic r);
        longint E;
        @(negedge clk_in);
        #1;
        x_in = X_W'(x); y_in = Y_W'(y); mask_in = m; valid_in = v; tabulate_in = tb; rst_in = r;
        E = edge_n + 1;
        for (int i = 0; i < 2; i++) model_edge(i, x, y, m, v, tb, r, E);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((edge_n + 1 <= last_e[0] + 1 || edge_n + 1 <= last_e[1] + 1) && guard < 2000) begin
            idle(1);
            guard++;
        end
        idle(2);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_x%0d", tag, i), xo[i], 0);
            chk($sformatf("%s_y%0d", tag, i), yo[i], 0);
            chk($sformatf("%s_ch%0d", tag, i), cho[i], 0);
            chk($sformatf("%s_found%0d", tag, i), fo[i], 0);
            chk($sformatf("%s_last%0d", tag, i), lo[i], 0);
            chk($sformatf("%s_valid%0d", tag, i), vo[i], 0);
            chk($sformatf("%s_busy%0d", tag, i), bo[i], 0);
        end
    endtask

    task automatic mon(input int i);
        longint E = edge_n + 1;
        exp_t   e;
        chk($sformatf("busy%0d", i), bo[i], (acc_e[i] + 1 <= E && E <= last_e[i]) ? 1 : 0);
        if (vo[i] === 1'b1) begin
            if (sb[i].size() == 0) chk($sformatf("unexpected_strobe%0d", i), 1, 0);
            else begin
                e = sb[i].pop_front();
                chk($sformatf("ch%0d", i), cho[i], e.ch);
                chk($sformatf("found%0d_ch%0d", i, e.ch), fo[i], e.found);
                chk($sformatf("last%0d_ch%0d", i, e.ch), lo[i], e.last);
                chk($sformatf("x%0d_ch%0d", i, e.ch), xo[i], e.x);
                chk($sformatf("y%0d_ch%0d", i, e.ch), yo[i], e.y);
                chk($sformatf("edge%0d_ch%0d", i, e.ch), E, e.at);
            end
        end
    endtask

    always @(negedge clk_in) if (mon_en) for (int i = 0; i < 2; i++) mon(i);

    initial begin
        drive(0, 0, '0, 1'b0, 1'b0, 1'b1);
        drive(0, 0, '0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check_zero("reset");
        mon_en = 1'b1;

        // Single-channel centroid
        drive(10, 20, 4'b0001, 1'b1, 1'b0, 1'b0);
        drive(20, 40, 4'b0001, 1'b1, 1'b0, 1'b0);
        drive(31, 61, 4'b0001, 1'b1, 1'b0, 1'b0);
        drive(0, 0, '0, 1'b0, 1'b1, 1'b0);
        drain();

        // Threshold: ch2 two pixels, ch3 three pixels
        repeat (2) drive(100, 50, 4'b0100, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(100, 50, 4'b1000, 1'b1, 1'b0, 1'b0);
        drive(0, 0, '0, 1'b0, 1'b1, 1'b0);
        drain();

        // Pixel coincident with tabulate belongs to the next frame
        drive(3, 3, 4'b0001, 1'b1, 1'b0, 1'b0);
        drive(7, 9, 4'b0001, 1'b1, 1'b1, 1'b0);
        drain();
        drive(0, 0, '0, 1'b0, 1'b1, 1'b0);
        drain();

        // Tabulate while busy is ignored and does not clear live sums
        drive(0, 0, '0, 1'b0, 1'b1, 1'b0);
        drive(4, 4, 4'b0010, 1'b1, 1'b0, 1'b0);
        drive(6, 6, 4'b0010, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(0, 0, '0, 1'b0, 1'b1, 1'b0);
        drain();
        drive(0, 0, '0, 1'b0, 1'b1, 1'b0);
        drain();

        // Reset in the middle of a divide
        repeat (3) drive(12, 14, 4'b0001, 1'b1, 1'b0, 1'b0);
        drive(0, 0, '0, 1'b0, 1'b1, 1'b0);
        idle(9);
        drive(0, 0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check_zero("midreset");
        idle(40);
        drive(0, 0, '0, 1'b0, 1'b1, 1'b0);
        drain();

        // All channels share the same pixels
        drive(0, 0, 4'b1111, 1'b1, 1'b0, 1'b0);
        drive(8, 4, 4'b1111, 1'b1, 1'b0, 1'b0);
        drive(0, 0, '0, 1'b0, 1'b1, 1'b0);
        drain();

        // Random traffic with random tabulates
        for (int k = 0; k < 600; k++)
            drive($urandom_range(0, 2047), $urandom_range(0, 1023), NUM_CH'($urandom),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), 1'b0);
        drive(0, 0, '0, 1'b0, 1'b0, 1'b0);
        drain();
        drive(0, 0, '0, 1'b0, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 2; i++) chk($sformatf("sb_empty%0d", i), sb[i].size(), 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multi_center_of_mass.md
Name: multi_center_of_mass

Overview:
- Parametrised successor to the single-blob centroid block.
- Accumulates pixel coordinates for NUM_CH independent masks (e.g. per-colour thresholds) in one pass over the frame.
- On tabulate, snapshots all channels and computes each centroid serially with one internal shift-subtract divider pair (x and y in parallel). Results stream out one channel per valid_out pulse, with a per-channel found flag.
- Sits between the threshold/mask stage and the crosshair/tracking logic.

Parameters:
- NUM_CH, 4: number of independent mask channels (≥1).
- X_W, 11: x coordinate width.
- Y_W, 10: y coordinate width.
- ACC_W, 32: width of the sum and count accumulators and of the dividers.
- MIN_PIXELS, 1: minimum pixel count for a channel to report found. A value of 0 is treated as 1.
- CH_W: localparam, max(1, $clog2(NUM_CH)).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- x_in  input  X_W  pixel x coordinate
- y_in  input  Y_W  pixel y coordinate
- mask_in  input  NUM_CH  per-channel membership of the current pixel
- valid_in  input  1  pixel qualifier
- tabulate_in  input  1  end of frame; request centroid computation
- x_out  output  X_W  centroid x (floor)
- y_out  output  Y_W  centroid y (floor)
- ch_out  output  CH_W  channel index of the current result
- found_out  output  1  count ≥ MIN_PIXELS for ch_out
- last_out  output  1  current result is channel NUM_CH-1
- valid_out  output  1  one-cycle result strobe
- busy_out  output  1  computation in progress; tabulate_in ignored while high

Behaviour:
- Reset (synchronous, rst_in=1 at a clock edge):
  - all outputs become 0;
  - live and snapshot accumulators cleared;
  - FSM goes to IDLE;
  - any in-flight computation is abandoned with no valid_out.
  - rst_in has priority over every other input.
- Accumulate:
  - Applies each cycle valid_in=1, for every channel c with mask_in[c]=1.
  - x_sum[c] += x_in, y_sum[c] += y_in, cnt[c] += 1.
  - All three saturate at 2^ACC_W-1 and never wrap.
  - mask_in is ignored when valid_in=0.
- Tabulate accept:
  - Condition: tabulate_in=1 and busy_out=0.
  - In that same edge, live accumulators copy to the snapshot registers and the live accumulators clear.
  - If valid_in=1 in that cycle, the pixel belongs to the NEW frame: the live accumulators load that pixel's contribution instead of 0.
  - busy_out rises at the next edge.
- Tabulate while busy_out=1: ignored. Live accumulators are not cleared and keep accumulating.
- FSM states: IDLE, SETUP, DIVIDE, EMIT; channel index k.
  - IDLE → SETUP on accept, with k=0.
  - SETUP:
    - If snap_cnt[k] < max(MIN_PIXELS,1), go to EMIT with found=0 and quotients forced to 0. This path never divides by zero.
    - Otherwise load both dividers (dividend snap_x_sum[k] / snap_y_sum[k], divisor snap_cnt[k]) and go to DIVIDE.
  - DIVIDE: restoring division, one quotient bit per cycle, exactly ACC_W cycles, then EMIT.
  - EMIT: valid_out=1 for exactly one cycle.
    - x_out = quotient_x[X_W-1:0], y_out = quotient_y[Y_W-1:0].
    - ch_out=k, found_out as determined in SETUP, last_out=(k==NUM_CH-1).
    - If last, go to IDLE; else k+1 and go to SETUP.
- Latency, with tabulate accepted at edge T:
  - a found channel takes ACC_W+2 cycles (SETUP + ACC_W + EMIT);
  - a skipped channel takes 2 cycles;
  - channel 0 found ⇒ valid_out high in cycle T+ACC_W+2.
- Output timing:
  - valid_out is low in all non-EMIT states.
  - x_out, y_out, ch_out, found_out and last_out hold their values between strobes.
- busy_out: high from the edge after accept through the final EMIT cycle inclusive; low the cycle after.
- Quotient is floor(sum/cnt). The result always fits X_W/Y_W because it is ≤ the maximum input, so truncation loses nothing when the sums are unsaturated.
- Saturated sums give implementation-defined but deterministic centroids. The bench must not check their values.

Test Plan:
- Centroid, single channel: NUM_CH=4, ACC_W=32, pixels (10,20), (20,40), (31,61) with mask 4'b0001, then tabulate.
  - ch0: x=20, y=40, found=1, valid_out at T+34.
  - ch1..3: found=0, x=y=0, ch_out=1,2,3, last_out only on ch3.
  - busy_out drops after the final EMIT.
- Threshold: MIN_PIXELS=3, ch2 gets 2 pixels and ch3 gets 3 pixels (all (100,50)), then tabulate.
  - ch2: found=0, emitted 2 cycles after its SETUP.
  - ch3: found=1, x=100, y=50.
- Simultaneous valid_in + tabulate: pixel (7,9) on ch0 in the tabulate cycle.
  - It is excluded from the current results.
  - The next tabulate with no other pixels gives ch0 x=7, y=9, found=1.
- Tabulate while busy: second tabulate 5 cycles after the first, with pixels (4,4), (6,6) on ch1 between.
  - Ignored: no extra strobes.
  - The next accepted tabulate gives ch1 (5,5), so the accumulators were not cleared by the ignored pulse.
- Reset mid-DIVIDE: assert rst_in 10 cycles after accept.
  - All outputs are 0 the next cycle and no valid_out follows.
  - A subsequent tabulate with no pixels yields found=0 on all channels.
- Multi-channel overlap: pixel (0,0) and (8,4) with mask 4'b1111.
  - All four channels report (4,2), found=1, in channel order 0..3.
